// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch/decode boundary: the fetch beat and the fetch queue sizing.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

  typedef logic [FQ_PTR_W-1:0] fq_ptr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw_instr;
    logic [31:0] iresp_data;
    logic        bubble;
    logic        valid;
  } fetch_data_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fetch_data_t      wdata,
  input  logic [PTR_W-1:0] raddr,
  output fetch_data_t      rdata
);

  fetch_data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode; absorbs decode stalls, flushed on branch redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  fetch_data_t      dataF,
  input  logic             push,
  output logic             q_full,
  input  logic             flush,
  output fetch_data_t      dataQ,
  output logic             q_valid,
  input  logic             pop,
  output logic [PTR_W:0]   q_count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [PTR_W:0]   count, count_nxt;
  logic             push_ok, pop_ok;
  fetch_data_t      head;

  assign push_ok = push & ~q_full & ~flush;
  assign pop_ok  = pop & q_valid & ~flush;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_ok) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr_nxt = rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // q_full/q_valid are registered from count_nxt so neither depends on same-cycle push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      q_full  <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      count   <= count_nxt;
      q_full  <= (count_nxt == CNT_FULL);
      q_valid <= (count_nxt != '0);
    end
  end

  fq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (dataF),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is not reset, so an empty queue presents a clean zero bubble instead of stale data.
  always_comb begin
    if (q_valid) begin
      dataQ        = head;
      dataQ.valid  = 1'b1;
      dataQ.bubble = 1'b0;
    end else begin
      dataQ        = '0;
      dataQ.bubble = 1'b1;
    end
  end

  assign q_count = count;

  // Fetch may still offer beats while full; these check that none are ever accepted.
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push_ok && q_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop_ok && !q_valid));
  a_count_range:  assert property (@(posedge clk) disable iff (!reset) count <= CNT_FULL);
  a_no_bubble:    assert property (@(posedge clk) disable iff (!reset) !(push && dataF.bubble));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of expected head entries against dataQ.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk;
  logic        reset;
  fetch_data_t dataF;
  logic        push;
  logic        q_full;
  logic        flush;
  fetch_data_t dataQ;
  logic        q_valid;
  logic        pop;
  logic [2:0]  q_count;

  int          total;
  int          bad;
  int          mcount;
  logic [31:0] exp_q[$];

  fetch_queue dut (
    .clk     (clk),
    .reset   (reset),
    .dataF   (dataF),
    .push    (push),
    .q_full  (q_full),
    .flush   (flush),
    .dataQ   (dataQ),
    .q_valid (q_valid),
    .pop     (pop),
    .q_count (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic p, input logic [31:0] pc);
    push             = p;
    dataF.pc         = pc;
    dataF.raw_instr  = ~pc;
    dataF.iresp_data = pc ^ 32'h5a5a_0000;
    dataF.valid      = p;
    dataF.bubble     = ~p;
  endtask

  task automatic idle_inputs();
    set_beat(1'b0, 32'h0);
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] head_pc;
    total++;
    if (q_count !== mcount[2:0]) begin
      bad++;
      $display("FAIL %s q_count got=%0d want=%0d", tag, q_count, mcount);
    end
    total++;
    if (q_valid !== (mcount != 0)) begin
      bad++;
      $display("FAIL %s q_valid got=%b want=%b", tag, q_valid, (mcount != 0));
    end
    total++;
    if (q_full !== (mcount == 4)) begin
      bad++;
      $display("FAIL %s q_full got=%b want=%b", tag, q_full, (mcount == 4));
    end
    total++;
    if (dataQ.valid !== (mcount != 0) || dataQ.bubble !== (mcount == 0)) begin
      bad++;
      $display("FAIL %s dataQ valid/bubble got=%b/%b want=%b/%b", tag,
               dataQ.valid, dataQ.bubble, (mcount != 0), (mcount == 0));
    end
    if (mcount != 0 && exp_q.size() != 0) begin
      head_pc = exp_q[0];
      total++;
      if (dataQ.pc !== head_pc || dataQ.raw_instr !== ~head_pc) begin
        bad++;
        $display("FAIL %s head pc got=%h want=%h raw got=%h want=%h", tag,
                 dataQ.pc, head_pc, dataQ.raw_instr, ~head_pc);
      end
    end
  endtask

  // Drive one cycle of stimulus, check the current state, then update the scoreboard.
  task automatic do_cycle(input logic p, input logic [31:0] pc, input logic po,
                          input logic fl, input string tag);
    logic acc_push, acc_pop;
    set_beat(p, pc);
    pop   = po;
    flush = fl;
    check_state(tag);
    acc_push = p && (mcount < 4) && !fl;
    acc_pop  = po && (mcount != 0) && !fl;
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (acc_pop) begin
        void'(exp_q.pop_front());
        mcount--;
      end
      if (acc_push) begin
        exp_q.push_back(pc);
        mcount++;
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_beat(1'b1, 32'h8000_0000);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q_valid !== 1'b0 || q_count !== 3'd0 || dataQ.valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold q_valid=%b q_count=%0d dataQ.valid=%b want 0/0/0",
               q_valid, q_count, dataQ.valid);
    end
    total++;
    if (dataQ.bubble !== 1'b1 || dataQ.pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_dataQ bubble=%b pc=%h want 1/00000000", dataQ.bubble, dataQ.pc);
    end
    reset = 1'b1;
    idle_inputs();
    exp_q.delete();
    mcount = 0;
    @(posedge clk);
    #1;
    do_cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, "reset_first_push");
    check_state("reset_first_visible");
    do_cycle(1'b0, 32'h0, 1'b1, 1'b0, "reset_drain");
    check_state("reset_empty");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0, "fill");
    total++;
    if (q_full !== 1'b1) begin
      bad++;
      $display("FAIL fill_full q_full got=%b want=1", q_full);
    end
    do_cycle(1'b1, 32'h8000_0010, 1'b0, 1'b0, "fill_5th");
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain");
    check_state("drain_empty");
  endtask

  task automatic test_wrap();
    do_cycle(1'b1, 32'h8000_0040, 1'b0, 1'b0, "wrap_pre");
    do_cycle(1'b1, 32'h8000_0044, 1'b0, 1'b0, "wrap_pre");
    for (int i = 0; i < 10; i++)
      do_cycle(1'b1, 32'h8000_0048 + 32'(4 * i), 1'b1, 1'b0, "wrap_pp");
    do_cycle(1'b0, 32'h0, 1'b1, 1'b0, "wrap_drain");
    do_cycle(1'b0, 32'h0, 1'b1, 1'b0, "wrap_drain");
    check_state("wrap_empty");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 32'h8000_00a0 + 32'(4 * i), 1'b0, 1'b0, "flush_pre");
    do_cycle(1'b1, 32'h8000_0100, 1'b1, 1'b1, "flush_cycle");
    check_state("flush_after");
    do_cycle(1'b1, 32'h8000_0200, 1'b0, 1'b0, "flush_push");
    total++;
    if (dataQ.pc !== 32'h8000_0200 || q_count !== 3'd1) begin
      bad++;
      $display("FAIL flush_next pc=%h count=%0d want 80000200/1", dataQ.pc, q_count);
    end
    do_cycle(1'b0, 32'h0, 1'b1, 1'b0, "flush_drain");
    check_state("flush_empty");
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 32'h8000_0300 + 32'(4 * i), 1'b0, 1'b0, "fp_fill");
    do_cycle(1'b1, 32'h8000_03f0, 1'b1, 1'b0, "fp_both");
    total++;
    if (q_count !== 3'd3 || q_full !== 1'b0 || dataQ.pc !== 32'h8000_0304) begin
      bad++;
      $display("FAIL full_pop count=%0d full=%b pc=%h want 3/0/80000304",
               q_count, q_full, dataQ.pc);
    end
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, "fp_drain");
    check_state("fp_empty");
  endtask

  task automatic test_async_reset();
    do_cycle(1'b1, 32'h8000_0400, 1'b0, 1'b0, "ar_fill");
    do_cycle(1'b1, 32'h8000_0404, 1'b0, 1'b0, "ar_fill");
    check_state("ar_loaded");
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (q_valid !== 1'b0 || q_count !== 3'd0 || dataQ.valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset q_valid=%b q_count=%0d dataQ.valid=%b want 0/0/0",
               q_valid, q_count, dataQ.valid);
    end
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("ar_released");
    do_cycle(1'b1, 32'h8000_0500, 1'b0, 1'b0, "ar_push");
    check_state("ar_push_visible");
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    mcount = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_full_pop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
